// File: rtl/integer_driver_pkg.sv
`default_nettype none
// ==========================================================================
// Module   : integers_pkg
// Summary  : Shared types, write-select codes and enum helpers for the
//            integer_driver block.
// Revision : 1.0 - initial release
// ==========================================================================
package integers_pkg;

  // Enum with deliberately sparse encodings so the simulator sees
  // non-contiguous legal values.
  typedef enum int {
    A = 0,
    B = 1,
    C = 45,
    D = 123789
  } enum_e;

  // Run controller states.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Write-port target codes; 6 and 7 complete the handshake but change nothing.
  localparam logic [2:0] SEL_ENUM     = 3'd0;
  localparam logic [2:0] SEL_BYTE     = 3'd1;
  localparam logic [2:0] SEL_SHORTINT = 3'd2;
  localparam logic [2:0] SEL_INT      = 3'd3;
  localparam logic [2:0] SEL_LONGINT  = 3'd4;
  localparam logic [2:0] SEL_INTEGER  = 3'd5;

  // Next member of the A->B->C->D->A sequence (never an arithmetic increment).
  function automatic enum_e enum_next(enum_e v);
    enum_e n;
    case (v)
      A:       n = B;
      B:       n = C;
      C:       n = D;
      default: n = A;
    endcase
    return n;
  endfunction

  // Map a raw write value onto a legal member; unknown encodings become A.
  function automatic enum_e enum_from_bits(logic [31:0] v);
    enum_e n;
    case (v)
      32'd1:      n = B;
      32'd45:     n = C;
      32'd123789: n = D;
      default:    n = A;
    endcase
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/integer_driver_if.sv
`default_nettype none
// ==========================================================================
// Module   : integer_driver_if
// Summary  : Valid/ready write port carrying a target select and a 64-bit
//            value into integer_driver.
// Revision : 1.0 - initial release
// ==========================================================================
interface integer_driver_if;

  logic        wr_valid;
  logic        wr_ready;
  logic [2:0]  wr_sel;
  logic [63:0] wr_data;

  modport master (
    output wr_valid,
    output wr_sel,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_sel,
    input  wr_data,
    output wr_ready
  );

endinterface
`default_nettype wire

// File: rtl/integer_driver_ctrl.sv
`default_nettype none
// ==========================================================================
// Module   : integer_driver_ctrl
// Summary  : IDLE/RUN controller for integer_driver. Latches the step,
//            counts update cycles and produces busy, done and wr_ready.
// Revision : 1.0 - initial release
// ==========================================================================
module integer_driver_ctrl
  import integers_pkg::*;
#(
  parameter int               NUM_STEPS    = 16,
  parameter logic signed [7:0] STEP_DEFAULT = 8'sd1
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              start,
  input  wire logic              stop,
  input  wire logic [7:0]        step_i,
  output logic                   busy,
  output logic                   done,
  output logic                   wr_ready,
  output logic                   update_en,
  output logic signed [7:0]      step
);

  // Counter value on the final update cycle of a run.
  localparam logic [15:0] c_last_count = 16'(NUM_STEPS - 1);

  state_e             r_state;
  logic [15:0]        r_count;
  logic signed [7:0]  r_step;
  logic               r_busy;
  logic               r_done;
  logic               r_wr_ready;

  // Value registers advance on every RUN cycle that is not being aborted.
  assign update_en = (r_state == RUN) && !stop;

  assign busy     = r_busy;
  assign done     = r_done;
  assign wr_ready = r_wr_ready;
  assign step     = r_step;

  // Run state machine with registered busy/done/wr_ready and step latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_step     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_wr_ready <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= RUN;
            r_count    <= '0;
            r_step     <= (step_i == 8'd0) ? STEP_DEFAULT : step_i;
            r_busy     <= 1'b1;
            r_wr_ready <= 1'b0;
          end
        end
        RUN: begin
          if (stop) begin
            // Abort: this cycle's update is suppressed and no done pulse.
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_wr_ready <= 1'b1;
          end else if (r_count == c_last_count) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_wr_ready <= 1'b1;
            r_done     <= 1'b1;
          end else begin
            r_count <= r_count + 16'd1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_busy     <= 1'b0;
          r_wr_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/integer_driver.sv
`default_nettype none
// ==========================================================================
// Module   : integer_driver
// Summary  : Drives one output of each SV integer kind from registered
//            state. Values load through a valid/ready write port and can be
//            auto-stepped by a run controller with signed wrap-around.
// Revision : 1.0 - initial release
// ==========================================================================
module integer_driver
  import integers_pkg::*;
#(
  parameter int               NUM_STEPS    = 16,
  parameter logic signed [7:0] STEP_DEFAULT = 8'sd1
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  integer_driver_if.slave wr,
  input  wire logic       start,
  input  wire logic       stop,
  input  wire logic [7:0] step_i,
  output enum_e           enum_output,
  output byte             byte_output,
  output shortint         shortint_output,
  output int              int_output,
  output longint          longint_output,
  output integer          integer_output,
  output logic            busy,
  output logic            done
);

  logic               w_update_en;
  logic               w_wr_fire;
  logic signed [7:0]  w_step;
  logic signed [15:0] w_step16;
  logic signed [31:0] w_step32;
  logic signed [63:0] w_step64;

  enum_e              r_enum;
  logic signed [7:0]  r_byte;
  logic signed [15:0] r_short;
  logic signed [31:0] r_int;
  logic signed [63:0] r_long;
  integer             r_integer;

  integer_driver_ctrl #(
    .NUM_STEPS    (NUM_STEPS),
    .STEP_DEFAULT (STEP_DEFAULT)
  ) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .step_i    (step_i),
    .busy      (busy),
    .done      (done),
    .wr_ready  (wr.wr_ready),
    .update_en (w_update_en),
    .step      (w_step)
  );

  assign w_wr_fire = wr.wr_valid && wr.wr_ready;

  // Sign-extend the latched step to every target width.
  assign w_step16 = {{8{w_step[7]}}, w_step};
  assign w_step32 = {{24{w_step[7]}}, w_step};
  assign w_step64 = {{56{w_step[7]}}, w_step};

  assign enum_output     = r_enum;
  assign byte_output     = r_byte;
  assign shortint_output = r_short;
  assign int_output      = r_int;
  assign longint_output  = r_long;
  assign integer_output  = r_integer;

  // Value registers: writes only land in IDLE, steps only in RUN, so the
  // two branches never compete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enum    <= A;
      r_byte    <= '0;
      r_short   <= '0;
      r_int     <= '0;
      r_long    <= '0;
      r_integer <= '0;
    end else if (w_wr_fire) begin
      case (wr.wr_sel)
        SEL_ENUM:     r_enum    <= enum_from_bits(wr.wr_data[31:0]);
        SEL_BYTE:     r_byte    <= wr.wr_data[7:0];
        SEL_SHORTINT: r_short   <= wr.wr_data[15:0];
        SEL_INT:      r_int     <= wr.wr_data[31:0];
        SEL_LONGINT:  r_long    <= wr.wr_data;
        SEL_INTEGER:  r_integer <= wr.wr_data[31:0];
        default:      ;
      endcase
    end else if (w_update_en) begin
      r_enum    <= enum_next(r_enum);
      r_byte    <= r_byte + w_step;
      r_short   <= r_short + w_step16;
      r_int     <= r_int + w_step32;
      r_long    <= r_long + w_step64;
      r_integer <= r_integer + w_step32;
    end
  end

endmodule
`default_nettype wire

// File: doc/integer_driver.md
Name: integer_driver

Overview:
- Output-side counterpart of the integer-type test top: drives one output of each SV integer kind (enum_e, byte, shortint, int, longint, integer) from registered state, for cocotb read-back tests.
- Values are loaded through a valid/ready write port, then optionally auto-stepped by a run state machine.
- This exercises signed wrap-around and enum sequencing as seen from the simulator.

Parameters:
- NUM_STEPS, 16, number of update cycles per run; legal range 1..65535.
- STEP_DEFAULT, 1, signed 8-bit increment used when step_i is 0.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr_valid  input  1  write request.
- wr_ready  output  1  high only in IDLE.
- wr_sel  input  3  target: 0 enum, 1 byte, 2 shortint, 3 int, 4 longint, 5 integer; 6 and 7 are ignored.
- wr_data  input  64  write value; truncated to the target width.
- start  input  1  single-cycle pulse; begins a run.
- stop  input  1  aborts a run.
- step_i  input  8  signed increment; 0 selects STEP_DEFAULT.
- enum_output  output  enum_e  current enum value.
- byte_output  output  byte  signed 8-bit value.
- shortint_output  output  shortint  signed 16-bit value.
- int_output  output  int  signed 32-bit value.
- longint_output  output  longint  signed 64-bit value.
- integer_output  output  integer  4-state 32-bit value.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when a run completes.

Behaviour:
- Reset: all value outputs 0, enum_output = A, busy = 0, done = 0, state = IDLE, step counter = 0.
- States:
  - IDLE: wr_ready = 1. A write transfers when wr_valid && wr_ready. The target register updates on that edge and is visible the next cycle.
  - IDLE to RUN: start in IDLE latches the step (step_i, or STEP_DEFAULT if 0) and clears the counter.
  - If start and a write transfer occur in the same cycle, the write lands first. The first increment is applied on the following edge.
  - RUN: each cycle, every numeric output += sign-extended step, wrapping modulo 2^width with no saturation.
  - RUN enum sequence: A→B→C→D→A. Encodings are 0, 1, 45, 123789; always a legal member, never an arithmetic increment.
  - RUN counter: increments each cycle. When it reaches NUM_STEPS-1, that cycle's update is applied, then state returns to IDLE and done pulses on the next cycle.
- Run length: exactly NUM_STEPS updates, so busy is high for NUM_STEPS cycles.
- stop in RUN: the update for that cycle is suppressed, state returns to IDLE, done is not pulsed, and outputs hold their current values.
- start in RUN is ignored. stop in IDLE is ignored. Writes are refused in RUN because wr_ready = 0.
- A wr_sel of 6 or 7 completes the handshake but changes nothing.
- An enum write with an encoding outside {0, 1, 45, 123789} maps to A.
- Reset asserted mid-run forces the reset values immediately, with no done pulse.
- integer_output is never X/Z after reset. Bit-exact equivalent of int_output arithmetic, but an independent register.
- Latency: write to output is 1 cycle; start to first update is 1 cycle.

Decomposition:
- Shared package integers_pkg:
  - typedef enum_e {A, B, C=45, D=123789};
  - function enum_next(enum_e), returning the next value in the A→B→C→D→A sequence;
  - localparams for the wr_sel codes (SEL_ENUM … SEL_INTEGER);
  - the FSM state typedef {IDLE, RUN}.
- One sub-module is natural: integer_driver_ctrl, holding the FSM, step counter, done/busy generation and the step latch. The value registers stay in the top.

Test Plan:
- Reset, then write byte=127 with step_i=1, start, NUM_STEPS=16. After run: byte_output=-113, enum_output=A (16 mod 4 = 0), done high for 1 cycle exactly 17 cycles after start.
- Write longint=64'h7FFF_FFFF_FFFF_FFFF, step_i=1, NUM_STEPS=1. Result: longint_output=-9223372036854775808, int_output=1, integer_output=1.
- step_i=-3 (8'hFD) from shortint=-32767, NUM_STEPS=1. Result: shortint_output=32766 (wrap); byte_output=-3.
- Enum write of 45, start, stop asserted on the 3rd RUN cycle. Result: enum_output=A (C→D→A, 3rd update suppressed), busy=0, no done pulse.
- Write enum 2 (illegal) → enum_output=A. wr_sel=7 write → no output changes. wr_valid during RUN → wr_ready=0 and values unchanged.
- Drop rst_n mid-run (cycle 5) → all outputs 0/A within the same cycle, busy=0. After release, a start in IDLE runs normally.
